// File: rtl/display_layer_pkg.sv
// Shared types and defaults for the display layer arbiter.
//   layer_mode_t : per-layer visibility mode as written through the config port
//   layer_shown  : visibility decode for one layer given its mode and the blink phase
package display_layer_pkg;

   localparam int unsigned NUM_LAYERS_DEF   = 16;
   localparam int unsigned RGB_W_DEF        = 8;
   localparam int unsigned BLINK_FRAMES_DEF = 16;

   typedef enum logic [1:0] {
      MODE_HIDDEN  = 2'd0,
      MODE_VISIBLE = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_RSVD    = 2'd3
   } layer_mode_t;

   // Reserved mode falls through to hidden; blink shows only in phase 0.
   function automatic logic layer_shown(input layer_mode_t mode, input logic blink_phase);
      return (mode == MODE_VISIBLE) || ((mode == MODE_BLINK) && !blink_phase);
   endfunction

endpackage

// File: rtl/display_layer_arbiter_blink_timer.sv
// blink_timer: frame counter that toggles the blink phase every BLINK_FRAMES frames.
//   clk, reset       : pixel clock, synchronous active-high reset
//   start_of_frame   : one-cycle pulse at the first pixel of each frame
//   blink_phase      : 0 = blinking layers shown, 1 = blinking layers hidden (registered)
module blink_timer #(
   parameter int unsigned BLINK_FRAMES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic start_of_frame,
   output logic blink_phase
);

   localparam int unsigned CNT_W = $clog2(BLINK_FRAMES);

   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             phase_q, phase_d;

   // Counter wraps naturally because BLINK_FRAMES is a power of two.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      phase_d     = phase_q;
      if (start_of_frame) begin
         frame_cnt_d = frame_cnt_q + CNT_W'(1);
         if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            phase_d = ~phase_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         phase_q     <= phase_d;
      end
   end

   assign blink_phase = phase_q;

endmodule

// File: rtl/display_layer_arbiter.sv
// display_layer_arbiter: per-pixel priority arbiter over NUM_LAYERS drawing layers with
// frame-synchronous visibility modes and a per-frame overlap report against layer 0.
//   clk, reset      : pixel clock, synchronous active-high reset
//   startOfFrame    : one-cycle pulse at first pixel of each frame
//   drawingRequest  : per-layer draw request, index 0 = highest priority
//   layerRGB        : per-layer RRRGGGBB colour
//   backGroundRGB   : colour used when no layer is eligible
//   cfgValid/cfgIndex/cfgMode/cfgReady : mode write handshake into the shadow array
//   rgbOut, layerId : registered winning colour and layer (NUM_LAYERS = background)
//   hitMask, hitValid : layers that overlapped layer 0 in the previous frame, update pulse
// Optional feature: define LAYER_BLINK_EN to build the blink timer; otherwise blink
// mode behaves as visible.
module display_layer_arbiter
   import display_layer_pkg::*;
#(
   parameter int unsigned NUM_LAYERS   = NUM_LAYERS_DEF,
   parameter int unsigned RGB_W        = RGB_W_DEF,
   parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          startOfFrame,
   input  logic [NUM_LAYERS-1:0]         drawingRequest,
   input  logic [RGB_W-1:0]              layerRGB [NUM_LAYERS],
   input  logic [RGB_W-1:0]              backGroundRGB,
   input  logic                          cfgValid,
   input  logic [$clog2(NUM_LAYERS)-1:0] cfgIndex,
   input  logic [1:0]                    cfgMode,
   output logic                          cfgReady,
   output logic [RGB_W-1:0]              rgbOut,
   output logic [$clog2(NUM_LAYERS):0]   layerId,
   output logic [NUM_LAYERS-1:0]         hitMask,
   output logic                          hitValid
);

   localparam int unsigned IDX_W = $clog2(NUM_LAYERS);
   localparam int unsigned ID_W  = IDX_W + 1;

   // A non-power-of-two period would not wrap the frame counter at the right count.
   if ((BLINK_FRAMES < 2) || ((BLINK_FRAMES & (BLINK_FRAMES - 1)) != 0)) begin : g_bad_blink_frames
      $error("BLINK_FRAMES must be a power of two and at least 2");
   end

   layer_mode_t           shadow_q [NUM_LAYERS];
   layer_mode_t           shadow_d [NUM_LAYERS];
   layer_mode_t           active_q [NUM_LAYERS];
   layer_mode_t           active_d [NUM_LAYERS];
   logic [NUM_LAYERS-1:0] acc_q, acc_d;
   logic [NUM_LAYERS-1:0] hit_mask_q, hit_mask_d;
   logic                  hit_valid_q, hit_valid_d;
   logic [RGB_W-1:0]      rgb_q, rgb_d;
   logic [ID_W-1:0]       layer_id_q, layer_id_d;

   logic                  blink_phase;
   logic [NUM_LAYERS-1:0] elig_c;
   logic [NUM_LAYERS-1:0] hit_c;

`ifdef LAYER_BLINK_EN
   blink_timer #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_blink_timer (
      .clk            (clk),
      .reset          (reset),
      .start_of_frame (startOfFrame),
      .blink_phase    (blink_phase)
   );
`else
   assign blink_phase = 1'b0;
`endif

   // The port accepts a write in any cycle reset is not holding the block.
   assign cfgReady = ~reset;

   // Eligibility and overlap with layer 0 for the current pixel.
   always_comb begin
      elig_c = '0;
      hit_c  = '0;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
         elig_c[i] = drawingRequest[i] & layer_shown(active_q[i], blink_phase);
      end
      for (int unsigned i = 1; i < NUM_LAYERS; i++) begin
         hit_c[i] = elig_c[0] & elig_c[i];
      end
   end

   // Mode arrays: shadow takes writes, active reloads from shadow (including a
   // same-cycle write) at each frame start.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (cfgValid && cfgReady) begin
         for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (cfgIndex == IDX_W'(i)) begin
               shadow_d[i] = layer_mode_t'(cfgMode);
            end
         end
      end
      if (startOfFrame) begin
         active_d = shadow_d;
      end
   end

   // Overlap accumulator; a hit in the frame-start cycle belongs to the new frame.
   always_comb begin
      acc_d       = acc_q | hit_c;
      hit_mask_d  = hit_mask_q;
      hit_valid_d = 1'b0;
      if (startOfFrame) begin
         hit_mask_d  = acc_q;
         hit_valid_d = 1'b1;
         acc_d       = hit_c;
      end
   end

   // Priority mux: scanning high to low leaves the lowest eligible index selected.
   always_comb begin
      rgb_d      = backGroundRGB;
      layer_id_d = ID_W'(NUM_LAYERS);
      for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
         if (elig_c[i]) begin
            rgb_d      = layerRGB[i];
            layer_id_d = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            shadow_q[i] <= MODE_VISIBLE;
            active_q[i] <= MODE_VISIBLE;
         end
         acc_q       <= '0;
         hit_mask_q  <= '0;
         hit_valid_q <= 1'b0;
         rgb_q       <= '0;
         layer_id_q  <= ID_W'(NUM_LAYERS);
      end else begin
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         acc_q       <= acc_d;
         hit_mask_q  <= hit_mask_d;
         hit_valid_q <= hit_valid_d;
         rgb_q       <= rgb_d;
         layer_id_q  <= layer_id_d;
      end
   end

   assign rgbOut   = rgb_q;
   assign layerId  = layer_id_q;
   assign hitMask  = hit_mask_q;
   assign hitValid = hit_valid_q;

endmodule

// File: doc/display_layer_arbiter.md
# display_layer_arbiter

Registered priority arbiter and layer controller for the VGA object path: selects, per pixel, the colour of the highest-priority visible layer that requests drawing, falling back to the background. Per-layer visibility modes (hidden / visible / blink) are written through a config handshake and applied only at frame boundaries, so the picture does not tear. It also reports a per-frame overlap mask between layer 0 (the player object) and every other layer. It sits between the object drawers and the 8-bit-to-24-bit colour expander feeding the VGA controller.

## Interface
- NUM_LAYERS, 16, number of requesters; index 0 = highest priority
- RGB_W, 8, packed RRRGGGBB colour width
- BLINK_FRAMES, 16, frames per blink half-period (power of two, ≥2)
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- startOfFrame  in  1  one-cycle pulse at first pixel of each frame
- drawingRequest  in  NUM_LAYERS  per-layer pixel request
- layerRGB  in  NUM_LAYERS×RGB_W  per-layer colour, unpacked array
- backGroundRGB  in  RGB_W  fallback colour
- cfgValid  in  1  config write request
- cfgIndex  in  $clog2(NUM_LAYERS)  target layer
- cfgMode  in  2  0 hidden, 1 visible, 2 blink, 3 reserved
- cfgReady  out  1  config write accepted when cfgValid & cfgReady
- rgbOut  out  RGB_W  selected colour
- layerId  out  $clog2(NUM_LAYERS)+1  winning layer; NUM_LAYERS = background
- hitMask  out  NUM_LAYERS  layers that overlapped layer 0 in the previous frame (bit 0 always 0)
- hitValid  out  1  one-cycle pulse when hitMask updates

## Operation
- Shadow mode array written on accepted config; active mode array loaded from shadow on startOfFrame.
- cfgReady is 1 in every cycle except while reset is asserted.
- Write and startOfFrame in same cycle: the write is included in the newly loaded active array.
- Reserved mode 3 behaves as hidden.
- Layer i eligible = drawingRequest[i] & (mode==visible | (mode==blink & blinkPhase==0)).
- Winner = lowest eligible index; no eligible layer → backGroundRGB, layerId = NUM_LAYERS.
- Blink: frame counter, width $clog2(BLINK_FRAMES), increments on startOfFrame, wraps to 0; on wrap blinkPhase toggles. blinkPhase starts at 0 (visible).
- Overlap accumulator: bit i (i≥1) set when layer 0 and layer i both eligible in the same cycle; on startOfFrame accumulator copied to hitMask, hitValid pulses, accumulator clears (a hit in the startOfFrame cycle itself goes into the fresh accumulator).
- Reset values: rgbOut 0, layerId NUM_LAYERS, hitMask 0, hitValid 0, shadow and active modes all visible, frame counter 0, blinkPhase 0, accumulator 0.

## Timing
- rgbOut/layerId: 1-cycle latency from drawingRequest/layerRGB (registered, same as existing mux stage).
- Mode write visible at output from the first pixel after the next startOfFrame (eligibility uses active array updated on that edge, so the pixel presented with startOfFrame+1 cycle uses new modes).
- hitMask/hitValid: registered in the cycle after startOfFrame.
- reset mid-frame: all state returns to reset values on the next edge; pending shadow writes lost.

## Configuration
- LAYER_BLINK_EN defined: blink mode, frame counter and blinkPhase implemented as above.
- Undefined: no counter logic; mode 2 treated as visible; blinkPhase constant 0.

## Structure
- Package display_layer_pkg: layer_mode_t enum (MODE_HIDDEN, MODE_VISIBLE, MODE_BLINK, MODE_RSVD), NUM_LAYERS_DEF, RGB_W_DEF.
- One sub-module: blink_timer (frame counter + blinkPhase), instantiated only under LAYER_BLINK_EN.

## Test plan
- After reset, requests 0 and 5 both high, RGB 0xE0/0x1C → rgbOut 0xE0, layerId 0 one cycle later.
- Write layer 0 hidden mid-frame → output unchanged until next startOfFrame, then 0x1C, layerId 5.
- No requests, backGroundRGB 0x03 → rgbOut 0x03, layerId 16.
- Layer 3 blink, BLINK_FRAMES=2, request held → visible frames 0–1, hidden 2–3, visible 4–5.
- Layers 0 and 7 overlap in frame N → hitMask 0x0080 with hitValid pulse after frame N+1 startOfFrame; no overlap in N+1 → 0x0000 after N+2.
- Config write coincident with startOfFrame → new mode effective immediately that frame; reset mid-frame → all modes visible, outputs 0/16.
